// File: rtl/fetch_stage_pkg.sv
// Shared ISA definitions for the instruction fetch stage.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0) shown to decode when idle
//   fetch_entry_t    : one buffered fetch result {pc, instruction}
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_fifo.sv
// fetch_fifo: circular buffer holding fetched instructions for decode.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push, push_data  write one entry (ignored while full unless popping too)
//   pop              remove the head entry (ignored while empty)
//   flush            discard every entry; wins over push and pop
//   head             oldest entry (contents undefined while empty)
//   count            number of valid entries
//   full, empty      occupancy flags
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  // A pop in the same cycle frees the slot, so a full FIFO may still push.
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries data only; validity is tracked by count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: credit-based instruction fetch with redirect and drop tracking.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   imem_req_valid/ready/addr     fetch request handshake to instruction memory
//   imem_rsp_valid/data           in-order responses, no back-pressure
//   redirect_valid/pc             new fetch target from later stages
//   id_valid/ready                handshake towards decode
//   id_instruction, id_pc         FIFO head (NOP / 0 when nothing is buffered)
//   fetch_fault                   last redirect target was misaligned; fetch halted
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic        fetch_fault
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [31:0]      pc;
  logic [CNT_W-1:0] in_flight;
  logic [CNT_W-1:0] drop_cnt;
  logic             fault;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic             push;
  logic             pop;
  logic             req_fire;
  logic [CNT_W:0]   credits_used;

  // Every buffered entry and every outstanding request holds one credit, so
  // a response always finds room in the FIFO even if decode never drains it.
  assign credits_used   = {1'b0, in_flight} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && !fault && !redirect_valid && !fifo_full &&
                          (credits_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses during a redirect or while stale requests drain are discarded.
  assign push = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign pop  = id_valid && id_ready;

  // With no stale requests outstanding, the in-flight requests were issued
  // back to back ending at pc-4, so the oldest one (this response) was
  // fetched from pc - 4*in_flight.
  assign push_entry.pc          = pc - (32'(in_flight) << 2);
  assign push_entry.instruction = imem_rsp_data;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign id_valid       = !fifo_empty;
  assign id_instruction = fifo_empty ? NOP_INSTR : fifo_head.instruction;
  assign id_pc          = fifo_empty ? 32'h0000_0000 : fifo_head.pc;
  assign fetch_fault    = fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      in_flight <= '0;
      drop_cnt  <= '0;
      fault     <= 1'b0;
    end else begin
      in_flight <= in_flight + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      if (redirect_valid) begin
        pc    <= redirect_pc;
        fault <= (redirect_pc[1:0] != 2'b00);
        // A response landing in the redirect cycle is already accounted for.
        drop_cnt <= in_flight - CNT_W'(imem_rsp_valid);
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  int cyc      = 0;
  int n0;

  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] issued[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Capture handshakes with the values present just before the edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (imem_req_valid && imem_req_ready) begin
        q_addr.push_back(imem_req_addr);
        q_due.push_back(cyc + lat);
        issued.push_back(imem_req_addr);
      end
      if (id_valid && id_ready) begin
        got_pc.push_back(id_pc);
        got_ins.push_back(id_instruction);
      end
    end
  end

  // Instruction memory: in-order, fixed latency, word = addr ^ 32'h1357_9BDF.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q_addr.delete();
      q_due.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = q_addr[0] ^ 32'h1357_9BDF;
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    issued.delete();
    got_pc.delete();
    got_ins.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic wait_issued(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && issued.size() < n; i++) @(negedge clk);
    check_eq(tag, (issued.size() >= n) ? 32'(n) : 32'(issued.size()), 32'(n));
  endtask

  task automatic wait_got(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && got_pc.size() < n; i++) @(negedge clk);
    check_eq(tag, (got_pc.size() >= n) ? 32'(n) : 32'(got_pc.size()), 32'(n));
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    #1;
    check_eq("redirect_cycle_no_req", 32'(imem_req_valid), 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_req_valid",  32'(imem_req_valid), 32'h0);
    check_eq("rst_id_valid",   32'(id_valid),       32'h0);
    check_eq("rst_id_instr",   id_instruction,      32'h0000_0013);
    check_eq("rst_id_pc",      id_pc,               32'h0);
    check_eq("rst_fault",      32'(fetch_fault),    32'h0);

    // Streaming fetch with a 1-cycle memory.
    lat = 1;
    clear_logs();
    rst = 1'b0;
    wait_issued("t1_issue_cnt", 3, 20);
    check_eq("t1_issue0", issued[0], 32'h0000_0000);
    check_eq("t1_issue1", issued[1], 32'h0000_0004);
    check_eq("t1_issue2", issued[2], 32'h0000_0008);
    wait_got("t1_got_cnt", 3, 20);
    check_eq("t1_pc0",  got_pc[0],  32'h0000_0000);
    check_eq("t1_ins0", got_ins[0], 32'h1357_9BDF);
    check_eq("t1_pc1",  got_pc[1],  32'h0000_0004);
    check_eq("t1_ins1", got_ins[1], 32'h1357_9BDB);
    check_eq("t1_pc2",  got_pc[2],  32'h0000_0008);
    check_eq("t1_ins2", got_ins[2], 32'h1357_9BD7);

    // Decode stalled: credits run out after two requests.
    id_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    check_eq("t2_issue_cnt", 32'(issued.size()), 32'd2);
    check_eq("t2_id_valid",  32'(id_valid),      32'h1);
    check_eq("t2_head_pc",   id_pc,              32'h0000_0000);
    check_eq("t2_head_ins",  id_instruction,     32'h1357_9BDF);
    check_eq("t2_req_low",   32'(imem_req_valid), 32'h0);
    check_eq("t2_req_addr",  imem_req_addr,      32'h0000_0008);
    id_ready = 1'b1;
    wait_got("t2_got_cnt", 3, 30);
    check_eq("t2_pc1",  got_pc[1], 32'h0000_0004);
    check_eq("t2_pc2",  got_pc[2], 32'h0000_0008);
    check_eq("t2_issue2", issued[2], 32'h0000_0008);

    // Redirect with two requests in flight on a slow memory.
    lat = 3;
    id_ready = 1'b1;
    do_reset();
    wait_issued("t3_issue_cnt", 2, 20);
    redirect(32'h0000_0100);
    check_eq("t3_id_valid_after", 32'(id_valid), 32'h0);
    wait_got("t3_got_cnt", 1, 40);
    check_eq("t3_pc0",    got_pc[0],  32'h0000_0100);
    check_eq("t3_ins0",   got_ins[0], 32'h1357_9ADF);
    check_eq("t3_issue2", issued[2],  32'h0000_0100);

    // Misaligned redirect flushes, faults and halts; aligned one recovers.
    lat = 1;
    id_ready = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("t4_fifo_busy", 32'(id_valid), 32'h1);
    redirect(32'h0000_0102);
    check_eq("t4_fault",     32'(fetch_fault),    32'h1);
    check_eq("t4_flushed",   32'(id_valid),       32'h0);
    check_eq("t4_req_low",   32'(imem_req_valid), 32'h0);
    n0 = issued.size();
    repeat (5) @(negedge clk);
    check_eq("t4_no_issue",  32'(issued.size()),  32'(n0));
    check_eq("t4_req_low2",  32'(imem_req_valid), 32'h0);
    got_pc.delete();
    got_ins.delete();
    id_ready = 1'b1;
    redirect(32'h0000_0200);
    check_eq("t4_fault_clr", 32'(fetch_fault), 32'h0);
    wait_got("t4_got_cnt", 1, 20);
    check_eq("t4_pc0",  got_pc[0],  32'h0000_0200);
    check_eq("t4_ins0", got_ins[0], 32'h1357_99DF);

    // Memory not ready: address holds; pc wraps after the top word.
    imem_req_ready = 1'b0;
    redirect(32'hFFFF_FFFC);
    got_pc.delete();
    got_ins.delete();
    n0 = issued.size();
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_hold_addr", imem_req_addr, 32'hFFFF_FFFC);
      @(negedge clk);
    end
    check_eq("t5_hold_valid", 32'(imem_req_valid), 32'h1);
    imem_req_ready = 1'b1;
    wait_issued("t5_issue_cnt", n0 + 2, 20);
    check_eq("t5_issue_top",  issued[n0],     32'hFFFF_FFFC);
    check_eq("t5_issue_wrap", issued[n0 + 1], 32'h0000_0000);
    wait_got("t5_got_cnt", 2, 20);
    check_eq("t5_pc0",  got_pc[0],  32'hFFFF_FFFC);
    check_eq("t5_ins0", got_ins[0], 32'hECA8_6423);
    check_eq("t5_pc1",  got_pc[1],  32'h0000_0000);
    check_eq("t5_ins1", got_ins[1], 32'h1357_9BDF);

    // Asynchronous reset while a request is still outstanding.
    lat = 3;
    id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 20 && !id_valid; i++) @(negedge clk);
    check_eq("t6_pre_id_valid", 32'(id_valid),      32'h1);
    check_eq("t6_pre_issued",   32'(issued.size()), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_req_valid", 32'(imem_req_valid), 32'h0);
    check_eq("t6_id_valid",  32'(id_valid),       32'h0);
    check_eq("t6_id_instr",  id_instruction,      32'h0000_0013);
    check_eq("t6_id_pc",     id_pc,               32'h0);
    check_eq("t6_fault",     32'(fetch_fault),    32'h0);
    repeat (2) @(negedge clk);
    clear_logs();
    lat = 1;
    id_ready = 1'b1;
    rst = 1'b0;
    #1;
    check_eq("t6_first_req",  32'(imem_req_valid), 32'h1);
    check_eq("t6_first_addr", imem_req_addr,       32'h0000_0000);
    wait_got("t6_got_cnt", 1, 20);
    check_eq("t6_pc0",  got_pc[0],  32'h0000_0000);
    check_eq("t6_ins0", got_ins[0], 32'h1357_9BDF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
